glitch_sweep_scheduler: RTL and testbench
=========================================

Name: glitch_sweep_scheduler

Overview:
- Sequences one automated glitch campaign over a 2-D grid of offset and duration values, instead of host-issued single shots.
- For each grid point it:
  - drives the offset and duration values,
  - pulses the target-reset request that arms the reset/offset/duration chain,
  - waits for the glitch to complete,
  - watches the target's serial line for a response,
  - emits one result record.
- Sits between command_processor (configuration and start) and the resetter/offset_counter/duration_counter chain.

Parameters:
- CNT_W, 32, width of offset/duration values and all configuration fields.
- OBS_CYCLES, 1200000, length of the response-observation window, in clk cycles.
- GLITCH_TIMEOUT, 16777216, maximum clk cycles to wait for glitch_done before the point is abandoned.

Ports:
- clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches the configuration and begins the sweep; ignored while busy.
- abort  in  1  single-cycle pulse; terminates the sweep.
- off_start / off_end / off_step  in  CNT_W each  offset sweep range and step.
- dur_start / dur_end / dur_step  in  CNT_W each  duration sweep range and step.
- glitch_done  in  1  level; high once the short glitch pulse has ended.
- target_rx  in  1  raw target UART line (asynchronous to clk).
- offset  out  CNT_W  current offset value, to offset_counter din.
- duration  out  CNT_W  current duration value, to duration_counter din.
- target_reset  out  1  one-cycle pulse that arms the resetter for the current point.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts the result record.
- res_code  out  2  result: 0 = no response, 1 = response seen, 2 = glitch timeout.
- sweep_done  out  1  one-cycle pulse after the last point is reported.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; offset and duration hold 0.
- target_rx is synchronised with a 2-FF synchroniser. A falling edge on the synchronised line is a "response". Reset value of the synchroniser flops is 1.
- start is sampled in IDLE only. On start:
  - all six configuration fields are latched into internal registers;
  - offset <= off_start, duration <= dur_start;
  - next state is ARM.
- A step of 0 is treated as 1.
- ARM (1 cycle): target_reset = 1; the observation and timeout counters are cleared. Next state is WAIT_GLITCH.
- WAIT_GLITCH:
  - glitch_done = 1 goes to OBSERVE.
  - If the timeout counter reaches GLITCH_TIMEOUT-1 first, res_code is set to 2 and the next state is REPORT.
- OBSERVE:
  - The counter runs OBS_CYCLES cycles.
  - A response edge goes to REPORT immediately with res_code = 1.
  - Window expiry goes to REPORT with res_code = 0.
  - A response edge in the same cycle as window expiry counts as code 1.
- REPORT:
  - res_valid = 1 and res_code stays stable.
  - offset and duration hold the point that produced the result; the consumer reads them as the record key.
  - res_valid stays high until res_ready; on the valid && ready cycle the next state is ADVANCE.
  - Latency from the response edge to res_valid is 3 cycles (2 for the synchroniser, 1 for the state change).
- ADVANCE (1 cycle): duration is the inner loop, offset is the outer loop. Next-value arithmetic uses CNT_W+1 bits, so overflow past 2^CNT_W-1 counts as "beyond end".
  - If duration + step ≤ dur_end: duration advances and the next state is ARM.
  - Else duration <= dur_start. If offset + step ≤ off_end, offset advances and the next state is ARM.
  - Else the next state is DONE.
- start > end on either axis: only the start value is used for that axis (a single point on that axis).
- DONE (1 cycle): sweep_done = 1, then IDLE. offset and duration keep their last values.
- abort (any non-IDLE state, highest priority):
  - next state is IDLE;
  - res_valid drops without handshake;
  - no further target_reset pulse;
  - no sweep_done.
- abort in IDLE has no effect. abort and start in the same cycle in IDLE: abort wins and start is ignored.
- Configuration input changes during a sweep have no effect, because the latched copies are used.

Optional Feature:
- Macro: SWEEP_REPEAT_EN.
- When defined:
  - adds input rep_count[7:0], latched at start;
  - each grid point is executed rep_count+1 times (ARM…REPORT repeated) before ADVANCE;
  - adds output rep_idx[7:0], which is valid during REPORT and resets to 0 at each new point.
- When undefined: each point runs exactly once and neither port exists.

Decomposition:
- Shared package glitch_pkg holds:
  - the state enum (IDLE, ARM, WAIT_GLITCH, OBSERVE, REPORT, ADVANCE, DONE);
  - the res_code constants RES_NONE = 0, RES_RESP = 1, RES_TIMEOUT = 2;
  - the CNT_W default.
- One natural sub-module, sweep_axis: holds the latched start/end/step for one axis and produces the current value, a wrap flag and an advance/reload control. It is instantiated twice, for offset and duration.

Test Plan:
- off 10..12 step 1, dur 5..6 step 1, glitch_done asserted 4 cycles after each target_reset, no target_rx activity, res_ready always high:
  - 6 results, all code 0;
  - order (10,5),(10,6),(11,5),(11,6),(12,5),(12,6);
  - sweep_done once.
- Single point (off 100..100, dur 3..3); target_rx pulled low 10 cycles into OBSERVE → code 1, res_valid rises exactly 3 cycles after the line falls.
- glitch_done held low, GLITCH_TIMEOUT overridden to 16 → code 2 after 16 cycles in WAIT_GLITCH, then the sweep advances.
- res_ready held low 50 cycles in REPORT → res_valid, res_code, offset and duration stable throughout; no new target_reset.
- abort in OBSERVE of the 2nd point → IDLE next cycle, busy 0, no sweep_done; rst_n low mid-sweep → all outputs 0 immediately.
- off_end = 2^32-1, off_step = 4, off_start = 2^32-3 → a single offset point; no wrap to a small value.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch sweep scheduler and its axis sequencers.
package glitch_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARM         = 3'd1,
    WAIT_GLITCH = 3'd2,
    OBSERVE     = 3'd3,
    REPORT      = 3'd4,
    ADVANCE     = 3'd5,
    DONE        = 3'd6
  } state_t;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_RESP    = 2'd1;
  localparam logic [1:0] RES_TIMEOUT = 2'd2;

endpackage

// File: rtl/sweep_axis.sv
// One sweep axis: latched start/end/step, current value and a "next step lies beyond end" flag.
module sweep_axis
  import glitch_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] cfg_start,
  input  logic [W-1:0] cfg_end,
  input  logic [W-1:0] cfg_step,
  input  logic         advance,
  input  logic         reload,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] start_r;
  logic [W-1:0] end_r;
  logic [W-1:0] step_r;
  logic [W:0]   next_s;

  // A zero step would stall the sweep forever, so it is stored as one.
  function automatic logic [W-1:0] eff_step(input logic [W-1:0] step);
    return (step == {W{1'b0}}) ? {{(W-1){1'b0}}, 1'b1} : step;
  endfunction

  // Next value is computed one bit wider so that overflow reads as beyond end.
  always_comb begin
    next_s = {1'b0, value} + {1'b0, step_r};
    wrap   = (next_s > {1'b0, end_r});
  end

  // Configuration latch and current-value register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= {W{1'b0}};
      end_r   <= {W{1'b0}};
      step_r  <= {{(W-1){1'b0}}, 1'b1};
      value   <= {W{1'b0}};
    end else if (load) begin
      start_r <= cfg_start;
      end_r   <= cfg_end;
      step_r  <= eff_step(cfg_step);
      value   <= cfg_start;
    end else if (advance) begin
      value <= next_s[W-1:0];
    end else if (reload) begin
      value <= start_r;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/glitch_sweep_scheduler.sv
// Automated 2-D offset/duration glitch campaign sequencer with result handshake.
// Optional per-point repetition is enabled by defining SWEEP_REPEAT_EN.
module glitch_sweep_scheduler
  import glitch_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEFAULT,
  parameter int OBS_CYCLES     = 1200000,
  parameter int GLITCH_TIMEOUT = 16777216
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] off_start,
  input  logic [CNT_W-1:0] off_end,
  input  logic [CNT_W-1:0] off_step,
  input  logic [CNT_W-1:0] dur_start,
  input  logic [CNT_W-1:0] dur_end,
  input  logic [CNT_W-1:0] dur_step,
  input  logic             glitch_done,
  input  logic             target_rx,
`ifdef SWEEP_REPEAT_EN
  input  logic [7:0]       rep_count,
  output logic [7:0]       rep_idx,
`endif
  output logic [CNT_W-1:0] offset,
  output logic [CNT_W-1:0] duration,
  output logic             target_reset,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_code,
  output logic             sweep_done
);

  localparam int TMO_W = $clog2(GLITCH_TIMEOUT + 1);
  localparam int OBS_W = $clog2(OBS_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GLITCH_TIMEOUT - 1);
  localparam logic [OBS_W-1:0] OBS_LAST = OBS_W'(OBS_CYCLES - 1);

  state_t           state_r;
  logic [TMO_W-1:0] tmo_r;
  logic [OBS_W-1:0] obs_r;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  logic             rx_fall_s;
  logic             load_s;
  logic             dur_adv_s;
  logic             dur_reload_s;
  logic             off_adv_s;
  logic             dur_wrap_s;
  logic             off_wrap_s;
`ifdef SWEEP_REPEAT_EN
  logic [7:0]       rep_cnt_r;
  logic [7:0]       rep_idx_r;

  assign rep_idx = rep_idx_r;
`endif

  assign busy      = (state_r != IDLE);
  assign rx_fall_s = rx_prev_r & ~rx_sync_r;

  // Two-flop synchroniser for the target UART line plus an edge-history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= target_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Axis controls; abort suppresses every value change.
  always_comb begin
    load_s       = 1'b0;
    dur_adv_s    = 1'b0;
    dur_reload_s = 1'b0;
    off_adv_s    = 1'b0;
    if (abort) begin
      load_s = 1'b0;
    end else if (state_r == IDLE) begin
      load_s = start;
    end else if (state_r == ADVANCE) begin
      dur_adv_s    = ~dur_wrap_s;
      dur_reload_s = dur_wrap_s;
      off_adv_s    = dur_wrap_s & ~off_wrap_s;
    end else begin
      load_s = 1'b0;
    end
  end

  sweep_axis #(.W(CNT_W)) u_off_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .cfg_start (off_start),
    .cfg_end   (off_end),
    .cfg_step  (off_step),
    .advance   (off_adv_s),
    .reload    (1'b0),
    .value     (offset),
    .wrap      (off_wrap_s)
  );

  sweep_axis #(.W(CNT_W)) u_dur_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .cfg_start (dur_start),
    .cfg_end   (dur_end),
    .cfg_step  (dur_step),
    .advance   (dur_adv_s),
    .reload    (dur_reload_s),
    .value     (duration),
    .wrap      (dur_wrap_s)
  );

  // Sweep state machine with registered strobes and result record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      tmo_r        <= {TMO_W{1'b0}};
      obs_r        <= {OBS_W{1'b0}};
      target_reset <= 1'b0;
      res_valid    <= 1'b0;
      res_code     <= RES_NONE;
      sweep_done   <= 1'b0;
`ifdef SWEEP_REPEAT_EN
      rep_cnt_r    <= 8'd0;
      rep_idx_r    <= 8'd0;
`endif
    end else if (abort && (state_r != IDLE)) begin
      state_r      <= IDLE;
      target_reset <= 1'b0;
      res_valid    <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      target_reset <= 1'b0;
      sweep_done   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            state_r      <= ARM;
            target_reset <= 1'b1;
`ifdef SWEEP_REPEAT_EN
            rep_cnt_r    <= rep_count;
            rep_idx_r    <= 8'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        ARM: begin
          tmo_r   <= {TMO_W{1'b0}};
          obs_r   <= {OBS_W{1'b0}};
          state_r <= WAIT_GLITCH;
        end
        WAIT_GLITCH: begin
          if (glitch_done) begin
            state_r <= OBSERVE;
          end else if (tmo_r == TMO_LAST) begin
            res_code  <= RES_TIMEOUT;
            res_valid <= 1'b1;
            state_r   <= REPORT;
          end else begin
            tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        OBSERVE: begin
          // An edge coinciding with window expiry still counts as a response.
          if (rx_fall_s) begin
            res_code  <= RES_RESP;
            res_valid <= 1'b1;
            state_r   <= REPORT;
          end else if (obs_r == OBS_LAST) begin
            res_code  <= RES_NONE;
            res_valid <= 1'b1;
            state_r   <= REPORT;
          end else begin
            obs_r <= obs_r + {{(OBS_W-1){1'b0}}, 1'b1};
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef SWEEP_REPEAT_EN
            if (rep_idx_r != rep_cnt_r) begin
              rep_idx_r    <= rep_idx_r + 8'd1;
              target_reset <= 1'b1;
              state_r      <= ARM;
            end else begin
              state_r <= ADVANCE;
            end
`else
            state_r <= ADVANCE;
`endif
          end else begin
            state_r <= REPORT;
          end
        end
        ADVANCE: begin
`ifdef SWEEP_REPEAT_EN
          rep_idx_r <= 8'd0;
`endif
          if (dur_wrap_s && off_wrap_s) begin
            sweep_done <= 1'b1;
            state_r    <= DONE;
          end else begin
            target_reset <= 1'b1;
            state_r      <= ARM;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sweep_scheduler.sv
// Scoreboard bench for glitch_sweep_scheduler: expected records queued at stimulus, compared at handshake.
module tb_glitch_sweep_scheduler;
  import glitch_pkg::*;

  typedef struct packed {
    logic [31:0] off;
    logic [31:0] dur;
    logic [1:0]  code;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] off_start = 32'd0, off_end = 32'd0, off_step = 32'd0;
  logic [31:0] dur_start = 32'd0, dur_end = 32'd0, dur_step = 32'd0;
  logic        glitch_done = 1'b0;
  logic        target_rx = 1'b1;
  logic [31:0] offset, duration;
  logic        target_reset, busy, res_valid, sweep_done;
  logic        res_ready = 1'b1;
  logic [1:0]  res_code;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tr_cnt = 0;
  int   sd_cnt = 0;
  int   res_cnt = 0;
  bit   glitch_en = 1'b1;

  always #5 clk = ~clk;

  glitch_sweep_scheduler #(
    .CNT_W          (32),
    .OBS_CYCLES     (40),
    .GLITCH_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .off_start    (off_start),
    .off_end      (off_end),
    .off_step     (off_step),
    .dur_start    (dur_start),
    .dur_end      (dur_end),
    .dur_step     (dur_step),
    .glitch_done  (glitch_done),
    .target_rx    (target_rx),
    .offset       (offset),
    .duration     (duration),
    .target_reset (target_reset),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_code     (res_code),
    .sweep_done   (sweep_done)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_rec(input logic [31:0] o, input logic [31:0] d, input logic [1:0] c);
    rec_t r;
    r.off  = o;
    r.dur  = d;
    r.code = c;
    exp_q.push_back(r);
  endtask

  // Latch a configuration with a one-cycle start, then scramble the inputs.
  task automatic run_sweep(input logic [31:0] os, input logic [31:0] oe, input logic [31:0] ost,
                           input logic [31:0] ds, input logic [31:0] de, input logic [31:0] dst);
    off_start = os; off_end = oe; off_step = ost;
    dur_start = ds; dur_end = de; dur_step = dst;
    start = 1'b1;
    tick();
    start = 1'b0;
    off_start = 32'h0bad_0000; off_end = 32'h0000_0001; off_step = 32'h0000_0007;
    dur_start = 32'h0bad_1111; dur_end = 32'h0000_0002; dur_step = 32'h0000_0009;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int n;
    base = sd_cnt;
    n = 0;
    while (sd_cnt == base && n < budget) begin
      tick();
      n++;
    end
    check_value(tag, 64'(sd_cnt - base), 64'd1);
    tick();
    tick();
  endtask

  // Glitch model: glitch_done rises 4 cycles after each target_reset pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (target_reset) begin
        glitch_done = 1'b0;
        if (glitch_en) begin
          repeat (4) @(posedge clk);
          #1;
          glitch_done = 1'b1;
        end
      end
    end
  end

  // Monitor: counts strobes and pops/compares a record on every handshake.
  initial begin
    forever begin
      rec_t e;
      @(negedge clk);
      if (rst_n) begin
        if (target_reset) tr_cnt++;
        if (sweep_done) sd_cnt++;
        if (res_valid && res_ready) begin
          res_cnt++;
          check_value("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_value("res_offset", 64'(offset), 64'(e.off));
            check_value("res_duration", 64'(duration), 64'(e.dur));
            check_value("res_code", 64'(res_code), 64'(e.code));
          end
        end
      end
    end
  end

  initial begin
    int n;
    int bad;
    int trb;
    int sdb;
    int rcb;

    repeat (3) @(posedge clk);
    #2;
    check_value("reset_outputs", 64'({offset, duration, target_reset, busy, res_valid, res_code, sweep_done}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full 3x2 grid, duration inner loop.
    for (int o = 10; o <= 12; o++)
      for (int d = 5; d <= 6; d++)
        push_rec(32'(o), 32'(d), RES_NONE);
    rcb = res_cnt;
    run_sweep(32'd10, 32'd12, 32'd1, 32'd5, 32'd6, 32'd1);
    check_value("busy_after_start", 64'(busy), 64'd1);
    wait_done("grid_done", 2000);
    check_value("grid_count", 64'(res_cnt - rcb), 64'd6);
    check_value("grid_idle", 64'(busy), 64'd0);

    // Response 10 cycles into the observation window.
    push_rec(32'd100, 32'd3, RES_RESP);
    run_sweep(32'd100, 32'd100, 32'd1, 32'd3, 32'd3, 32'd1);
    n = 0;
    while (!glitch_done && n < 100) begin
      tick();
      n++;
    end
    repeat (10) tick();
    target_rx = 1'b0;
    tick();
    tick();
    check_value("resp_lat_2", 64'(res_valid), 64'd0);
    tick();
    check_value("resp_lat_3", 64'(res_valid), 64'd1);
    wait_done("resp_done", 200);
    target_rx = 1'b1;
    tick();
    tick();

    // Glitch timeout on two points.
    glitch_en = 1'b0;
    push_rec(32'd7, 32'd1, RES_TIMEOUT);
    push_rec(32'd7, 32'd2, RES_TIMEOUT);
    run_sweep(32'd7, 32'd7, 32'd1, 32'd1, 32'd2, 32'd1);
    check_value("tmo_arm", 64'(target_reset), 64'd1);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    check_value("tmo_wait_cycles", 64'(n), 64'd17);
    wait_done("tmo_done", 300);
    glitch_en = 1'b1;

    // Back-pressure: record holds while res_ready is low.
    res_ready = 1'b0;
    push_rec(32'd20, 32'd30, RES_NONE);
    run_sweep(32'd20, 32'd20, 32'd1, 32'd30, 32'd30, 32'd1);
    n = 0;
    while (!res_valid && n < 200) begin
      tick();
      n++;
    end
    trb = tr_cnt;
    bad = 0;
    repeat (50) begin
      tick();
      if (!(res_valid && res_code == RES_NONE && offset == 32'd20 && duration == 32'd30)) bad++;
    end
    check_value("hold_stable", 64'(bad), 64'd0);
    check_value("hold_no_arm", 64'(tr_cnt - trb), 64'd0);
    res_ready = 1'b1;
    wait_done("hold_done", 100);

    // Abort in OBSERVE of the second point.
    push_rec(32'd1, 32'd1, RES_NONE);
    trb = tr_cnt;
    run_sweep(32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd1);
    n = 0;
    while (tr_cnt < trb + 2 && n < 200) begin
      tick();
      n++;
    end
    n = 0;
    while (!glitch_done && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    sdb = sd_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_value("abort_idle", 64'({busy, res_valid}), 64'd0);
    trb = tr_cnt;
    repeat (60) tick();
    check_value("abort_no_done", 64'(sd_cnt - sdb), 64'd0);
    check_value("abort_no_arm", 64'(tr_cnt - trb), 64'd0);
    check_value("abort_q_empty", 64'(exp_q.size()), 64'd0);

    // Zero steps behave as one.
    push_rec(32'd0, 32'd0, RES_NONE);
    push_rec(32'd0, 32'd1, RES_NONE);
    push_rec(32'd0, 32'd2, RES_NONE);
    run_sweep(32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0);
    wait_done("step0_done", 500);

    // Offset overflow past end and duration start > end: a single point.
    push_rec(32'hFFFF_FFFD, 32'd9, RES_NONE);
    rcb = res_cnt;
    run_sweep(32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd4, 32'd9, 32'd3, 32'd1);
    wait_done("ovf_done", 300);
    check_value("ovf_count", 64'(res_cnt - rcb), 64'd1);
    check_value("ovf_offset_kept", 64'(offset), 64'hFFFF_FFFD);

    // Asynchronous reset mid-sweep.
    run_sweep(32'd1, 32'd1, 32'd1, 32'd1, 32'd3, 32'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_value("rst_mid_outputs", 64'({offset, duration, target_reset, busy, res_valid, res_code, sweep_done}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_value("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
